// File: rtl/rmii_tx_sched.sv
// Round-robin two-source transmit scheduler: serializes 32-bit words into RMII dibits MSB-first and enforces the IFG.
// Optional feature macro: RMII_TX_PREAMBLE_EN prefixes each frame with 7x 0x55 + 0xD5 (preamble/SFD).
module rmii_tx_sched #(
    parameter int IFG_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_axiiv,
    input  logic [63:0] req_axiid,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        underrun
);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
`ifdef RMII_TX_PREAMBLE_EN
        ,
        PRE   = 2'd3
`endif
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               last_grant;
    logic [3:0]         dibit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [31:0]        shreg;
    logic               last_lat;
    logic               winner;
    logic               sel;
    logic [31:0]        sel_word;
    logic               sel_last;
    logic               accept;
    logic               shift_en;
`ifdef RMII_TX_PREAMBLE_EN
    logic [4:0]         pre_cnt;
`endif

    // In IDLE the arbiter winner feeds the word mux; during a frame only the owner does.
    always_comb begin
        winner   = (req_axiiv == 2'b11) ? ~last_grant : req_axiiv[1];
        sel      = (state == IDLE) ? winner : grant[1];
        sel_word = sel ? req_axiid[63:32] : req_axiid[31:0];
        sel_last = req_last[sel];
        accept   = |(req_ready & req_axiiv);
    end

    always_comb begin
        next_state = state;
        req_ready  = 2'b00;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_axiiv) begin
                    req_ready = {winner, ~winner};
`ifdef RMII_TX_PREAMBLE_EN
                    next_state = PRE;
`else
                    next_state = SHIFT;
`endif
                end
            end
`ifdef RMII_TX_PREAMBLE_EN
            PRE: begin
                if (pre_cnt == 5'd31) begin
                    next_state = SHIFT;
                    shift_en   = 1'b1;
                end
            end
`endif
            SHIFT: begin
                if (dibit_cnt == 4'd15) begin
                    if (last_lat) begin
                        next_state = GAP;
                    end else begin
                        req_ready = grant;
                        if (!(|(grant & req_axiiv))) next_state = GAP;
                    end
                end else begin
                    shift_en = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word storage carries no reset; it is only consumed after a fresh load.
    always_ff @(posedge clk) begin
        if (accept) begin
            last_lat <= sel_last;
`ifdef RMII_TX_PREAMBLE_EN
            if (state == IDLE) shreg <= sel_word;
            else               shreg <= {sel_word[29:0], 2'b00};
`else
            shreg <= {sel_word[29:0], 2'b00};
`endif
        end else if (shift_en) begin
            shreg <= {shreg[29:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            axiov      <= 1'b0;
            axiod      <= 2'b00;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            dibit_cnt  <= 4'd0;
            gap_cnt    <= '0;
`ifdef RMII_TX_PREAMBLE_EN
            pre_cnt    <= 5'd0;
`endif
        end else begin
            state    <= next_state;
            busy     <= (next_state != IDLE);
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant      <= {winner, ~winner};
                        last_grant <= winner;
                        axiov      <= 1'b1;
                        dibit_cnt  <= 4'd0;
`ifdef RMII_TX_PREAMBLE_EN
                        axiod      <= 2'b01;
                        pre_cnt    <= 5'd0;
`else
                        axiod      <= sel_word[31:30];
`endif
                    end
                end
`ifdef RMII_TX_PREAMBLE_EN
                PRE: begin
                    pre_cnt <= pre_cnt + 5'd1;
                    if (pre_cnt == 5'd31)      axiod <= shreg[31:30];
                    else if (pre_cnt == 5'd30) axiod <= 2'b11;
                end
`endif
                SHIFT: begin
                    if (dibit_cnt == 4'd15) begin
                        if (accept) begin
                            axiod     <= sel_word[31:30];
                            dibit_cnt <= 4'd0;
                        end else begin
                            axiov    <= 1'b0;
                            axiod    <= 2'b00;
                            grant    <= 2'b00;
                            gap_cnt  <= '0;
                            underrun <= ~last_lat;
                        end
                    end else begin
                        axiod     <= shreg[31:30];
                        dibit_cnt <= dibit_cnt + 4'd1;
                    end
                end
                GAP: gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rmii_tx_sched.sv
// Scoreboard bench for rmii_tx_sched: expected dibits are queued on each word handoff and popped per stream cycle.
module tb_rmii_tx_sched;
    localparam int IFG = 48;
`ifdef RMII_TX_PREAMBLE_EN
    localparam int PRE_LEN = 32;
`else
    localparam int PRE_LEN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_axiiv;
    logic [63:0] req_axiid;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        axiov;
    logic [1:0]  axiod;
    logic [1:0]  grant;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    rmii_tx_sched #(.IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst), .req_axiiv(req_axiiv), .req_axiid(req_axiid),
        .req_last(req_last), .req_ready(req_ready), .axiov(axiov), .axiod(axiod),
        .grant(grant), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // {axiov, axiod, grant, busy, underrun, req_ready}
    function automatic logic [8:0] obs();
        return {axiov, axiod, grant, busy, underrun, req_ready};
    endfunction

    task automatic push_word(input logic [31:0] w, input bit first);
        if (first)
            for (int i = 0; i < PRE_LEN; i++) exp_q.push_back((i == PRE_LEN - 1) ? 2'b11 : 2'b01);
        for (int b = 15; b >= 0; b--) exp_q.push_back(w[2*b +: 2]);
    endtask

    function automatic logic [1:0] pop_exp();
        if (exp_q.size() == 0) return 2'bxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_axiiv = 2'b00; req_axiid = '0; req_last = 2'b00;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0) begin errors++; $display("FAIL reset_hold: got %b expected %b", obs(), 9'b0); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs(), 9'b0); end
        next_cycle();
    endtask

    task automatic test_single_word();
        logic [1:0] e;
        req_axiiv = 2'b01; req_axiid = {32'h0, 32'hA5C3_0F1E}; req_last = 2'b01;
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0_00_00_0_0_01) begin errors++; $display("FAIL single_accept: got %b expected %b", obs(), 9'b0_00_00_0_0_01); end
        push_word(32'hA5C3_0F1E, 1'b1);
        next_cycle();
        req_axiiv = 2'b00;
        for (int i = 0; i < PRE_LEN + 16; i++) begin
            @(negedge clk);
            e = pop_exp();
            checks++;
            if (obs() !== {1'b1, e, 2'b01, 1'b1, 1'b0, 2'b00}) begin
                errors++; $display("FAIL single_dibit%0d: got %b expected %b", i, obs(), {1'b1, e, 2'b01, 1'b1, 1'b0, 2'b00});
            end
            next_cycle();
        end
        for (int i = 0; i < IFG; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 9'b0_00_00_1_0_00) begin errors++; $display("FAIL single_gap%0d: got %b expected %b", i, obs(), 9'b0_00_00_1_0_00); end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0) begin errors++; $display("FAIL single_idle: got %b expected %b", obs(), 9'b0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_leftover: got %0d expected 0", exp_q.size()); end
        next_cycle();
    endtask

    task automatic test_multi_word();
        logic [31:0] w[3];
        logic [1:0] e;
        logic [1:0] rr;
        bit bound;
        int widx;
        for (int k = 0; k < 3; k++) w[k] = $urandom;
        // Source 0 stays valid throughout; it must never be readied during source 1's frame or gap.
        req_axiiv = 2'b11; req_axiid = {w[0], 32'hDEAD_BEEF}; req_last = 2'b01;
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0_00_00_0_0_10) begin errors++; $display("FAIL multi_accept: got %b expected %b", obs(), 9'b0_00_00_0_0_10); end
        push_word(w[0], 1'b1);
        next_cycle();
        req_axiiv = 2'b01;
        for (int i = 0; i < PRE_LEN + 48; i++) begin
            bound = (i >= PRE_LEN) && (((i - PRE_LEN) % 16) == 15);
            widx  = (i - PRE_LEN) / 16;
            if (bound) begin
                req_axiiv[1] = 1'b1;
                if (widx < 2) begin
                    req_axiid[63:32] = w[widx + 1];
                    req_last[1] = (widx + 1 == 2);
                end
            end
            rr = (bound && widx < 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            e = pop_exp();
            checks++;
            if (obs() !== {1'b1, e, 2'b10, 1'b1, 1'b0, rr}) begin
                errors++; $display("FAIL multi_dibit%0d: got %b expected %b", i, obs(), {1'b1, e, 2'b10, 1'b1, 1'b0, rr});
            end
            if (bound && widx < 2) push_word(w[widx + 1], 1'b0);
            next_cycle();
            req_axiiv[1] = 1'b0;
        end
        for (int i = 0; i < IFG; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 9'b0_00_00_1_0_00) begin errors++; $display("FAIL multi_gap%0d: got %b expected %b", i, obs(), 9'b0_00_00_1_0_00); end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0_00_00_0_0_01) begin errors++; $display("FAIL multi_idle: got %b expected %b", obs(), 9'b0_00_00_0_0_01); end
        req_axiiv = 2'b00;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL multi_leftover: got %0d expected 0", exp_q.size()); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd0, wd1;
        logic [1:0] e;
        logic [1:0] g;
        rst = 1'b1; req_axiiv = 2'b00;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        wd0 = $urandom; wd1 = $urandom;
        req_axiid = {wd1, wd0}; req_last = 2'b11; req_axiiv = 2'b11;
        for (int f = 0; f < 4; f++) begin
            g = (f % 2 == 1) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if (obs() !== {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, g}) begin
                errors++; $display("FAIL b2b_accept%0d: got %b expected %b", f, obs(), {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, g});
            end
            push_word(g[1] ? wd1 : wd0, 1'b1);
            next_cycle();
            if (g[1]) begin wd1 = $urandom; req_axiid[63:32] = wd1; end
            else      begin wd0 = $urandom; req_axiid[31:0]  = wd0; end
            for (int i = 0; i < PRE_LEN + 16; i++) begin
                @(negedge clk);
                e = pop_exp();
                checks++;
                if (obs() !== {1'b1, e, g, 1'b1, 1'b0, 2'b00}) begin
                    errors++; $display("FAIL b2b_dibit%0d_%0d: got %b expected %b", f, i, obs(), {1'b1, e, g, 1'b1, 1'b0, 2'b00});
                end
                next_cycle();
            end
            for (int i = 0; i < IFG; i++) begin
                @(negedge clk);
                checks++;
                if (obs() !== 9'b0_00_00_1_0_00) begin errors++; $display("FAIL b2b_gap%0d_%0d: got %b expected %b", f, i, obs(), 9'b0_00_00_1_0_00); end
                next_cycle();
            end
        end
        req_axiiv = 2'b00;
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0) begin errors++; $display("FAIL b2b_idle: got %b expected %b", obs(), 9'b0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
        next_cycle();
    endtask

    task automatic test_underrun();
        logic [31:0] w;
        logic [1:0] e;
        logic [1:0] rr;
        w = $urandom;
        req_axiiv = 2'b01; req_axiid = {32'h0, w}; req_last = 2'b00;
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0_00_00_0_0_01) begin errors++; $display("FAIL urun_accept: got %b expected %b", obs(), 9'b0_00_00_0_0_01); end
        push_word(w, 1'b1);
        next_cycle();
        req_axiiv = 2'b00;
        for (int i = 0; i < PRE_LEN + 16; i++) begin
            rr = (i == PRE_LEN + 15) ? 2'b01 : 2'b00;
            @(negedge clk);
            e = pop_exp();
            checks++;
            if (obs() !== {1'b1, e, 2'b01, 1'b1, 1'b0, rr}) begin
                errors++; $display("FAIL urun_dibit%0d: got %b expected %b", i, obs(), {1'b1, e, 2'b01, 1'b1, 1'b0, rr});
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0_00_00_1_1_00) begin errors++; $display("FAIL urun_pulse: got %b expected %b", obs(), 9'b0_00_00_1_1_00); end
        next_cycle();
        for (int i = 1; i < IFG; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 9'b0_00_00_1_0_00) begin errors++; $display("FAIL urun_gap%0d: got %b expected %b", i, obs(), 9'b0_00_00_1_0_00); end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0) begin errors++; $display("FAIL urun_idle: got %b expected %b", obs(), 9'b0); end
        next_cycle();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w, w2;
        logic [1:0] e;
        w = $urandom; w2 = $urandom;
        req_axiiv = 2'b10; req_axiid = {w, 32'h0}; req_last = 2'b10;
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0_00_00_0_0_10) begin errors++; $display("FAIL rstmid_accept: got %b expected %b", obs(), 9'b0_00_00_0_0_10); end
        push_word(w, 1'b1);
        next_cycle();
        req_axiiv = 2'b00;
        for (int i = 0; i < PRE_LEN + 7; i++) begin
            if (i == PRE_LEN + 6) rst = 1'b1;
            @(negedge clk);
            e = pop_exp();
            checks++;
            if (obs() !== {1'b1, e, 2'b10, 1'b1, 1'b0, 2'b00}) begin
                errors++; $display("FAIL rstmid_dibit%0d: got %b expected %b", i, obs(), {1'b1, e, 2'b10, 1'b1, 1'b0, 2'b00});
            end
            next_cycle();
        end
        rst = 1'b0;
        exp_q.delete();
        req_axiiv = 2'b01; req_axiid = {32'h0, w2}; req_last = 2'b01;
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0_00_00_0_0_01) begin errors++; $display("FAIL rstmid_after: got %b expected %b", obs(), 9'b0_00_00_0_0_01); end
        push_word(w2, 1'b1);
        next_cycle();
        req_axiiv = 2'b00;
        for (int i = 0; i < PRE_LEN + 16; i++) begin
            @(negedge clk);
            e = pop_exp();
            checks++;
            if (obs() !== {1'b1, e, 2'b01, 1'b1, 1'b0, 2'b00}) begin
                errors++; $display("FAIL rstmid_new%0d: got %b expected %b", i, obs(), {1'b1, e, 2'b01, 1'b1, 1'b0, 2'b00});
            end
            next_cycle();
        end
        for (int i = 0; i < IFG; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 9'b0_00_00_1_0_00) begin errors++; $display("FAIL rstmid_gap%0d: got %b expected %b", i, obs(), 9'b0_00_00_1_0_00); end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (obs() !== 9'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected %b", obs(), 9'b0); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_leftover: got %0d expected 0", exp_q.size()); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_back_to_back();
        test_underrun();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rmii_tx_sched.md
# rmii_tx_sched

Transmit-side scheduler for the RMII Ethernet path. It arbitrates two 32-bit frame sources round-robin and serializes the granted frame into a 2-bit dibit stream, MSB-first, so that each word's bits [31:30] are sent first. This ordering and the axiov/axiod framing match the receive-side word aggregator, so the two can loop back. The block also enforces the inter-frame gap and flags source underruns.

## Interface
Parameters:
- IFG_CYCLES, 48, idle cycles inserted after every frame (12 bytes × 4 dibits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_axiiv  in  2  per-source word valid; source i is bit i.
- req_axiid  in  64  per-source word; source i occupies [32i+31:32i].
- req_last  in  2  marks the current word as the final word of its frame; sampled with the word.
- req_ready  out  2  per-source word accept strobe, combinational.
- axiov  out  1  dibit stream valid; high for the whole frame.
- axiod  out  2  dibit; 0 whenever axiov=0.
- grant  out  2  one-hot owner of the current frame; 0 when idle or in the gap.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse when a frame is aborted.

## Operation
- States:
  - IDLE
  - PRE (only when the macro is defined)
  - SHIFT
  - GAP
- A word transfers on any edge where req_axiiv[i] && req_ready[i].
- IDLE:
  - If any req_axiiv bit is set, choose a winner. When both are set, the source other than last_grant wins.
  - req_ready[winner]=1 in the same cycle.
  - On the edge: load the word into the shift register, latch last, set grant and last_grant, clear dibit_cnt, go to SHIFT (or PRE).
- SHIFT:
  - Drive axiod=shreg[31:30] with axiov=1.
  - Each cycle: shift left by 2, increment the 4-bit dibit_cnt.
  - At dibit_cnt=15 with latched last=0: req_ready[grant]=1.
    - If the word is accepted, load it and stay in SHIFT; the stream continues with no bubble.
    - If req_axiiv[grant]=0, abort: pulse underrun, go to GAP.
  - At dibit_cnt=15 with last=1: go to GAP.
- GAP:
  - axiov=0, grant=0.
  - Count IFG_CYCLES cycles, then return to IDLE.
- req_ready is never asserted outside the two cases above. The non-granted source is never readied during a frame.
- req_axiid and req_last of the non-handshaking source are ignored.
- Reset values:
  - axiov=0, axiod=0, grant=0, req_ready=0, busy=0, underrun=0.
  - State=IDLE, last_grant=1, so source 0 wins the first tie.
- Reset mid-frame or mid-gap: the next cycle shows axiov=0 and IDLE. No gap is inserted.

## Timing
- axiov, axiod, grant, busy and underrun are registered. req_ready is combinational from state, dibit_cnt and req_axiiv.
- Word accepted at edge k in IDLE:
  - The first dibit (bits [31:30]) appears in cycle k+1.
  - The 16th dibit appears in cycle k+16.
- An N-word frame holds axiov high for exactly 16N consecutive cycles.
- After the last dibit:
  - axiov=0 for IFG_CYCLES cycles.
  - The earliest next accept is in the following IDLE cycle.
  - The earliest next first dibit therefore follows IFG_CYCLES+1 low cycles.
- Underrun:
  - Detected on the 16th dibit's cycle; that dibit is still sent.
  - axiov falls the next cycle, the same cycle underrun pulses.
- A single-word frame (req_last=1 on the first word) gives 16 dibits, then the gap.

## Configuration
- RMII_TX_PREAMBLE_EN:
  - Defined: after the IDLE accept the block enters PRE for 32 cycles before SHIFT. It drives axiov=1 with axiod=2'b01 for 31 cycles, then 2'b11 (the SFD, 0x55×7 then 0xD5, sent LSB-first). The first data dibit moves to k+33, and a frame lasts 32+16N cycles.
  - Undefined: the PRE state does not exist and frames begin directly with data.

## Test plan
- Source 0 sends one word 0xA5C3_0F1E with last=1 -> 16 dibits 10,10,01,01,11,00,00,11,00,00,11,11,00,01,11,10 in cycles k+1..k+16, then 48 cycles of axiov=0.
- Source 1 sends a 3-word frame, each word offered at its dibit_cnt=15 -> axiov high for 48 contiguous cycles, grant=2'b10, req_ready[0] never high.
- Both sources request continuously with 1-word frames after reset -> grants alternate 0,1,0,1, with each frame separated by 48 idle cycles.
- Source 0's first word has last=0 and req_axiiv[0] drops before dibit 15 -> 16 dibits, then underrun=1 for one cycle, axiov=0, gap, IDLE.
- rst asserted at dibit 7 of a frame -> the next cycle shows axiov=0, grant=0, busy=0; a new request is accepted in the cycle right after rst deasserts.
- With RMII_TX_PREAMBLE_EN defined, send a 1-word frame -> 31 dibits of 01, one of 11, then data, 48 cycles total.
